// File: rtl/fp_addsub_execute_unit_if.sv
// fp_addsub_execute_unit_if: operand/result bundle for the FP add/sub execute stage.
// master drives operands and receives results; slave is the execute unit.
// Zero is present only when FPADDSUB_EXEC_ZERO_FLAG_EN is defined.
interface fp_addsub_execute_unit_if #(parameter int MW = 25);
  logic          in_valid;
  logic [MW-1:0] Mmax;
  logic [MW-1:0] Mmin;
  logic          Sa;
  logic          Sb;
  logic          MaxAB;
  logic          OpMode;
  logic          G;
  logic          S;
  logic          out_valid;
  logic [MW:0]   Sum;
  logic          Sgn;
  logic          Gout;
  logic          Sout;
`ifdef FPADDSUB_EXEC_ZERO_FLAG_EN
  logic          Zero;
  modport master (output in_valid, Mmax, Mmin, Sa, Sb, MaxAB, OpMode, G, S,
                  input out_valid, Sum, Sgn, Gout, Sout, Zero);
  modport slave  (input in_valid, Mmax, Mmin, Sa, Sb, MaxAB, OpMode, G, S,
                  output out_valid, Sum, Sgn, Gout, Sout, Zero);
`else
  modport master (output in_valid, Mmax, Mmin, Sa, Sb, MaxAB, OpMode, G, S,
                  input out_valid, Sum, Sgn, Gout, Sout);
  modport slave  (input in_valid, Mmax, Mmin, Sa, Sb, MaxAB, OpMode, G, S,
                  output out_valid, Sum, Sgn, Gout, Sout);
`endif
endinterface

// File: rtl/fp_addsub_execute_unit.sv
// fp_addsub_execute_unit: effective add/subtract of pre-aligned mantissas plus result sign, 1-cycle registered.
// Ports: clk, rst (async, active-high), io (slave modport: operands in, Sum/Sgn/Gout/Sout/out_valid out).
// Optional FPADDSUB_EXEC_ZERO_FLAG_EN adds a registered Zero flag for an all-zero Sum.
module fp_addsub_execute_unit #(parameter int MW = 25) (
  input logic                    clk,
  input logic                    rst,
  fp_addsub_execute_unit_if.slave io
);
  logic        eop;
  logic [MW:0] sum_d, sum_q;
  logic        sgn_d, sgn_q, g_q, s_q, valid_q;
  always_comb begin
    eop   = io.Sa ^ io.Sb ^ io.OpMode;
    sum_d = eop ? {1'b0, io.Mmax} - {1'b0, io.Mmin} : {1'b0, io.Mmax} + {1'b0, io.Mmin};
    sgn_d = io.MaxAB ? io.Sb ^ io.OpMode : io.Sa;
  end
`ifdef FPADDSUB_EXEC_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) zero_q <= 1'b0;
    else if (io.in_valid) zero_q <= ~|sum_d;
  assign io.Zero = zero_q;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      sgn_q   <= 1'b0;
      g_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      valid_q <= io.in_valid;
      if (io.in_valid) begin
        sum_q <= sum_d;
        sgn_q <= sgn_d;
        g_q   <= io.G;
        s_q   <= io.S;
      end
    end
  end
  assign io.out_valid = valid_q;
  assign io.Sum       = sum_q;
  assign io.Sgn       = sgn_q;
  assign io.Gout      = g_q;
  assign io.Sout      = s_q;
endmodule

// File: tb/tb_fp_addsub_execute_unit.sv
// tb_fp_addsub_execute_unit: directed-vector bench for fp_addsub_execute_unit.
module tb_fp_addsub_execute_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [29:0] obs, exp;
  fp_addsub_execute_unit_if #(.MW(25)) io();
  fp_addsub_execute_unit #(.MW(25)) dut (.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;
  assign obs = {io.out_valid, io.Sum, io.Sgn, io.Gout, io.Sout};
  task automatic drive(input logic v, input logic [24:0] mx, input logic [24:0] mn,
                       input logic sa, input logic sb, input logic mab, input logic op,
                       input logic g, input logic s);
    io.in_valid = v; io.Mmax = mx; io.Mmin = mn; io.Sa = sa; io.Sb = sb;
    io.MaxAB = mab; io.OpMode = op; io.G = g; io.S = s;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    drive(1'b1, 25'h1FFFFFF, 25'h1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    exp = '0;
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset got %h exp %h", obs, exp); end
`ifdef FPADDSUB_EXEC_ZERO_FLAG_EN
    vectors++;
    if (io.Zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero got %b exp 0", io.Zero); end
`endif
    step();
    drive(1'b0, 25'h0, 25'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask
  task automatic test_add();
    drive(1'b1, 25'h1000000, 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp = {1'b1, 26'h1800000, 3'b000};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL add_nocarry got %h exp %h", obs, exp); end
`ifdef FPADDSUB_EXEC_ZERO_FLAG_EN
    vectors++;
    if (io.Zero !== 1'b0) begin miscompares++; $display("FAIL add_zero got %b exp 0", io.Zero); end
`endif
    drive(1'b1, 25'h0000001, 25'h0000001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp = {1'b1, 26'h0000002, 3'b100};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL add_negative got %h exp %h", obs, exp); end
  endtask
  task automatic test_carry();
    drive(1'b1, 25'h1800000, 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp = {1'b1, 26'h2000000, 3'b000};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL add_carry got %h exp %h", obs, exp); end
    drive(1'b1, 25'h1400000, 25'h0A00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp = {1'b1, 26'h1E00000, 3'b000};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL add_nocarry2 got %h exp %h", obs, exp); end
    drive(1'b1, 25'h1FFFFFF, 25'h1FFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp = {1'b1, 26'h3FFFFFE, 3'b000};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL add_max got %h exp %h", obs, exp); end
  endtask
  task automatic test_sub_opmode();
    drive(1'b1, 25'h1000000, 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    exp = {1'b1, 26'h0800000, 3'b000};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL sub_op_maxa got %h exp %h", obs, exp); end
    drive(1'b1, 25'h1000000, 25'h0800000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    exp = {1'b1, 26'h0800000, 3'b100};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL sub_op_maxb got %h exp %h", obs, exp); end
  endtask
  task automatic test_sub_signs();
    drive(1'b1, 25'h1000000, 25'h0400000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    exp = {1'b1, 26'h0C00000, 3'b100};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL sub_signs got %h exp %h", obs, exp); end
    drive(1'b1, 25'h1000000, 25'h1000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    exp = {1'b1, 26'h0000000, 3'b000};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL sub_exact_zero got %h exp %h", obs, exp); end
`ifdef FPADDSUB_EXEC_ZERO_FLAG_EN
    vectors++;
    if (io.Zero !== 1'b1) begin miscompares++; $display("FAIL sub_zero_flag got %b exp 1", io.Zero); end
`endif
  endtask
  task automatic test_back_to_back();
    drive(1'b1, 25'h1000000, 25'h0000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    exp = {1'b1, 26'h1000100, 3'b010};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL b2b_first got %h exp %h", obs, exp); end
    drive(1'b1, 25'h1FFFFFF, 25'h0000001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL b2b_stable got %h exp %h", obs, exp); end
    step();
    exp = {1'b1, 26'h1FFFFFE, 3'b101};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL b2b_second got %h exp %h", obs, exp); end
  endtask
  task automatic test_idle_hold();
    drive(1'b0, 25'h0123456, 25'h0000007, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    exp = {1'b0, 26'h1FFFFFE, 3'b101};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL idle_hold got %h exp %h", obs, exp); end
  endtask
  task automatic test_async_reset();
    drive(1'b1, 25'h1000000, 25'h0000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    exp = {1'b1, 26'h1000010, 3'b011};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL pre_reset got %h exp %h", obs, exp); end
    #2;
    rst = 1'b1;
    #1;
    exp = '0;
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL async_reset got %h exp %h", obs, exp); end
    step();
    drive(1'b0, 25'h1000000, 25'h0000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    step();
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL post_reset_idle got %h exp %h", obs, exp); end
    drive(1'b1, 25'h1200000, 25'h0200000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    exp = {1'b1, 26'h1000000, 3'b101};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL post_reset_valid got %h exp %h", obs, exp); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_carry();
    test_sub_opmode();
    test_sub_signs();
    test_back_to_back();
    test_idle_hold();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
